// File: rtl/spi_arbiter.sv
// Two-requester round-robin arbiter in front of a single SPI master.
// One owner is granted at a time. The arbiter fires spi_start, then waits
// for spi_done, or gives up after TIMEOUT cycles. It returns a one-cycle ack
// and an optional idle gap before it arbitrates again.
//
// state  | meaning
// IDLE   | no owner; req sampled here only
// LAUNCH | owner latched, spi_start pulsed
// WAIT   | frame in flight; timeout counter runs
// RESP   | ack = grant for one cycle, err valid
// GAP    | grant cleared; GAP_CYCLES idle cycles before IDLE
module spi_arbiter #(
  parameter int DATA_W     = 16,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              spi_start,
  output logic [DATA_W-1:0] spi_txdata,
  output logic              spi_sel,
  input  logic              spi_done,
  input  logic [DATA_W-1:0] spi_rxdata
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LAUNCH = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] RESP   = 3'd3;
  localparam logic [2:0] GAP    = 3'd4;

  // One counter serves both WAIT (timeout) and GAP, so it is sized for the larger limit.
  localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int GAP_M1  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_M1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          last_sel;
  logic          err_q;
  logic          pick_sel;

  // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    pick_sel = 1'b0;
    case (req)
      2'b01:   pick_sel = 1'b0;
      2'b10:   pick_sel = 1'b1;
      2'b11:   pick_sel = ~last_sel;
      default: pick_sel = 1'b0;
    endcase
  end

  // Sequencer state, owner latches, timeout/gap counter and response capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_sel   <= 1'b1;
      err_q      <= 1'b0;
      rdata      <= '0;
      grant      <= 2'b00;
      spi_txdata <= '0;
      spi_sel    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            grant      <= pick_sel ? 2'b10 : 2'b01;
            spi_sel    <= pick_sel;
            spi_txdata <= pick_sel ? wdata1 : wdata0;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A done that lands on the last timeout cycle still counts as success.
          if (spi_done) begin
            rdata <= spi_rxdata;
            err_q <= 1'b0;
            state <= RESP;
          end else if (cnt == TO_LAST) begin
            rdata <= '0;
            err_q <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          last_sel <= spi_sel;
          grant    <= 2'b00;
          cnt      <= '0;
          state    <= (GAP_CYCLES > 0) ? GAP : IDLE;
        end
        GAP: begin
          if (cnt == GAP_LAST) state <= IDLE;
          else                 cnt   <= cnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pulse-type outputs decode straight from the state register, so reset clears them immediately.
  always_comb begin
    busy      = (state != IDLE);
    spi_start = (state == LAUNCH);
    ack       = (state == RESP) ? grant : 2'b00;
    err       = (state == RESP) & err_q;
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: single transfer, round-robin tie, timeout,
// stray spi_done and mid-transaction reset.
module tb_spi_arbiter;

  localparam int DATA_W     = 16;
  localparam int GAP_CYCLES = 2;
  localparam int TIMEOUT    = 64;

  logic              clk;
  logic              reset;
  logic [1:0]        req;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        ack;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        grant;
  logic              busy;
  logic              spi_start;
  logic [DATA_W-1:0] spi_txdata;
  logic              spi_sel;
  logic              spi_done;
  logic [DATA_W-1:0] spi_rxdata;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int n_start  = 0;
  int n_ack    = 0;

  spi_arbiter #(.DATA_W(DATA_W), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .ack        (ack),
    .err        (err),
    .rdata      (rdata),
    .grant      (grant),
    .busy       (busy),
    .spi_start  (spi_start),
    .spi_txdata (spi_txdata),
    .spi_sel    (spi_sel),
    .spi_done   (spi_done),
    .spi_rxdata (spi_rxdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (spi_start) n_start <= n_start + 1;
    if (ack != 2'b00) n_ack <= n_ack + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_start(input string tag, output int c);
    logic found;
    found = 1'b0;
    c = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (spi_start) begin
        found = 1'b1;
        c = cyc;
      end
    end
    check(tag, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_ack(input string tag, output int c);
    logic found;
    found = 1'b0;
    c = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        found = 1'b1;
        c = cyc;
      end
    end
    check(tag, {31'd0, found}, 32'd1);
  endtask

  // Drives a one-cycle spi_done; returns at the following negedge.
  task automatic pulse_done(input logic [DATA_W-1:0] d);
    spi_done   = 1'b1;
    spi_rxdata = d;
    @(negedge clk);
    spi_done   = 1'b0;
    spi_rxdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
  endtask

  int s_cyc, a_cyc, prev_ack, base_ack;
  logic [1:0]        exp_g [3];
  logic [DATA_W-1:0] exp_tx [3];
  logic [DATA_W-1:0] exp_rx [3];

  initial begin
    reset = 1'b0; req = 2'b00; wdata0 = '0; wdata1 = '0;
    spi_done = 1'b0; spi_rxdata = '0;
    do_reset();

    check("rst_state", {ack, err, grant, busy, spi_start, spi_sel}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_txdata", spi_txdata, 32'h0);

    // Single requester 0; requester drops req after grant.
    req = 2'b01; wdata0 = 16'hA569;
    wait_start("t1_start", s_cyc);
    check("t1_txdata", spi_txdata, 32'hA569);
    check("t1_sel", spi_sel, 32'd0);
    check("t1_grant", grant, 32'h1);
    check("t1_busy", busy, 32'd1);
    req = 2'b00;
    tick(19);
    pulse_done(16'h3425);
    check("t1_ack", ack, 32'h1);
    check("t1_rdata", rdata, 32'h3425);
    check("t1_err", err, 32'd0);
    tick(1);
    check("t1_ack_one_cycle", ack, 32'h0);
    check("t1_gap_grant", grant, 32'h0);
    check("t1_gap_busy", busy, 32'd1);
    check("t1_nstart", n_start, 32'd1);

    // Stray done in GAP, then in IDLE.
    pulse_done(16'hFFFF);
    tick(4);
    check("stray_idle_busy", busy, 32'd0);
    pulse_done(16'hEEEE);
    tick(2);
    check("stray_rdata", rdata, 32'h3425);
    check("stray_nack", n_ack, 32'd1);
    check("stray_busy", busy, 32'd0);
    check("stray_nstart", n_start, 32'd1);

    // Fresh reset so the pointer is back at 1; both request continuously.
    do_reset();
    exp_g[0] = 2'b01; exp_tx[0] = 16'h2563; exp_rx[0] = 16'h1111;
    exp_g[1] = 2'b10; exp_tx[1] = 16'h9B63; exp_rx[1] = 16'h2222;
    exp_g[2] = 2'b01; exp_tx[2] = 16'h2563; exp_rx[2] = 16'h3333;
    req = 2'b11; wdata0 = 16'h2563; wdata1 = 16'h9B63;
    prev_ack = 0;
    for (int k = 0; k < 3; k++) begin
      wait_start($sformatf("rr%0d_start", k), s_cyc);
      check($sformatf("rr%0d_grant", k), grant, {30'd0, exp_g[k]});
      check($sformatf("rr%0d_txdata", k), spi_txdata, {16'd0, exp_tx[k]});
      // ack cycle, GAP_CYCLES gap cycles, one IDLE cycle, then LAUNCH.
      if (k > 0) check($sformatf("rr%0d_gap", k), s_cyc - prev_ack, GAP_CYCLES + 2);
      tick(3);
      if (k == 2) req = 2'b00;
      pulse_done(exp_rx[k]);
      check($sformatf("rr%0d_ack", k), ack, {30'd0, exp_g[k]});
      check($sformatf("rr%0d_rdata", k), rdata, {16'd0, exp_rx[k]});
      prev_ack = cyc;
    end

    // Timeout on requester 1, then a normal transfer.
    req = 2'b10; wdata1 = 16'h6A61;
    wait_start("to_start", s_cyc);
    check("to_sel", spi_sel, 32'd1);
    req = 2'b00;
    wait_ack("to_ack_seen", a_cyc);
    check("to_latency", a_cyc - s_cyc, TIMEOUT + 1);
    check("to_ack", ack, 32'h2);
    check("to_err", err, 32'd1);
    check("to_rdata", rdata, 32'h0);
    tick(1);
    check("to_err_clear", err, 32'd0);
    req = 2'b01; wdata0 = 16'h1234;
    wait_start("after_to_start", s_cyc);
    req = 2'b00;
    tick(5);
    pulse_done(16'h0BEE);
    check("after_to_ack", ack, 32'h1);
    check("after_to_err", err, 32'd0);
    check("after_to_rdata", rdata, 32'h0BEE);

    // Reset in the middle of WAIT.
    tick(6);
    req = 2'b01; wdata0 = 16'h5A5A;
    wait_start("mr_start", s_cyc);
    tick(3);
    base_ack = n_ack;
    reset = 1'b0;
    #1;
    check("mr_outputs", {ack, err, grant, busy, spi_start, spi_sel}, 32'd0);
    check("mr_rdata", rdata, 32'h0);
    check("mr_txdata", spi_txdata, 32'h0);
    tick(2);
    check("mr_no_ack", n_ack - base_ack, 32'd0);
    reset = 1'b1;
    wait_start("mr2_start", s_cyc);
    check("mr2_grant", grant, 32'h1);
    check("mr2_txdata", spi_txdata, 32'h5A5A);
    req = 2'b00;
    tick(4);
    pulse_done(16'h0C0C);
    check("mr2_ack", ack, 32'h1);
    check("mr2_rdata", rdata, 32'h0C0C);
    check("mr2_err", err, 32'd0);
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset: one clock; reset is asynchronous and active-low.
REQ-002 Parameter DATA_W, default 16, SPI word width in bits.
REQ-003 Parameter GAP_CYCLES, default 2, idle cycles inserted between back-to-back transactions (0 allowed).
REQ-004 Parameter TIMEOUT, default 64, maximum cycles in WAIT before abort (>= 2).
REQ-005 Ports (name  direction  width  meaning):
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req  input  2  per-requester transaction request, level, held until ack
- wdata0  input  DATA_W  requester 0 transmit word, stable while req[0]=1
- wdata1  input  DATA_W  requester 1 transmit word, stable while req[1]=1
- ack  output  2  one-cycle completion pulse, one-hot
- err  output  1  high with ack when the transaction timed out
- rdata  output  DATA_W  received word, valid in the ack cycle, held until next ack
- grant  output  2  one-hot owner of the SPI master, 0 when idle
- busy  output  1  high in any state other than IDLE
- spi_start  output  1  one-cycle start pulse to the SPI master
- spi_txdata  output  DATA_W  word to transmit, registered, stable from LAUNCH through WAIT
- spi_sel  output  1  slave/chip-select index (= granted requester)
- spi_done  input  1  one-cycle pulse from the SPI master at end of frame
- spi_rxdata  input  DATA_W  received word, valid when spi_done=1

Function
REQ-006 FSM states SHALL be IDLE, LAUNCH, WAIT, RESP, GAP, encoded in registers.
REQ-007 IDLE: if req!=0, the arbiter SHALL select a requester, set grant, latch its wdata into spi_txdata and the index into spi_sel, and go to LAUNCH the next cycle; else remain in IDLE.
REQ-008 Arbitration SHALL be round-robin: a single req is granted directly; if both are high, the requester not granted last SHALL win; the last-granted pointer resets to 1 so requester 0 wins the first tie.
REQ-009 LAUNCH: spi_start SHALL be 1 for exactly this cycle; next state WAIT.
REQ-010 WAIT: a timeout counter SHALL count from 0; on spi_done=1 capture spi_rxdata into rdata, clear err, go RESP; if the counter reaches TIMEOUT-1 without spi_done, set rdata to 0, set err, go RESP.
REQ-011 spi_done arriving in any state other than WAIT SHALL be ignored.
REQ-012 RESP: ack SHALL equal grant for exactly one cycle, err valid in the same cycle; last-granted pointer updated; next state GAP if GAP_CYCLES>0, else IDLE.
REQ-013 GAP: hold grant at 0, count GAP_CYCLES cycles, then IDLE; req sampled only in IDLE.
REQ-014 Latency: request in IDLE at cycle N -> spi_start at N+1 -> ack at cycle after spi_done +1.
REQ-015 A requester dropping req after grant SHALL NOT abort the transaction; the ack pulse still occurs.
REQ-016 A requester holding req after its ack SHALL be treated as a new request; with both requesting continuously, grants SHALL alternate.
REQ-017 grant SHALL be nonzero from LAUNCH through RESP and zero in IDLE and GAP; busy=0 only in IDLE.

Reset
REQ-018 On reset low, asynchronously: state IDLE, ack=0, err=0, rdata=0, grant=0, busy=0, spi_start=0, spi_txdata=0, spi_sel=0, counters 0, last-granted=1.
REQ-019 Reset asserted mid-transaction SHALL abandon it with no ack; after release the block SHALL arbitrate anew from IDLE.

Verification
REQ-020 req=01, wdata0=A569; model returns spi_done with 3425 after 20 cycles -> spi_start once, spi_txdata=A569, spi_sel=0, ack=01, rdata=3425, err=0.
REQ-021 req=11 held, wdata0=2563, wdata1=9B63 -> first grant 01 (txdata 2563), then 10 (9B63), then 01; GAP_CYCLES idle cycles between each ack and the next spi_start.
REQ-022 req=10, wdata1=6A61, no spi_done -> ack=10 with err=1 and rdata=0 exactly TIMEOUT cycles after entering WAIT; next transaction completes normally.
REQ-023 Stray spi_done pulse in IDLE and GAP -> no state change, no ack, rdata unchanged.
REQ-024 reset driven low during WAIT -> all outputs 0 immediately; no ack; after release req=01 completes normally with grant 01.
